// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the single-slave bus arbiter: FSM states and command codes.
package bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i, wrapping, one-hot out.
module rr_picker #(
  parameter int NM = 4,
  parameter int LW = $clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic [NM-1:0] win_o
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    // Offset 1..NM so the last winner is searched last.
    for (int k = 1; k <= NM; k++) begin
      idx = LW'((int'(last_i) + k) % NM);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to single-slave arbiter: round-robin grant, combinational request forwarding,
// slave-ack timeout and master abort handling.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NM    = 4,
  parameter int CMD_W = 1,
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int SW    = 4,
  parameter int TMO   = 256
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [NM-1:0]     iMstReq,
  input  logic [NM*CMD_W-1:0] iMstCmd,
  input  logic [NM*AW-1:0]  iMstAddr,
  input  logic [NM*SW-1:0]  iMstSel,
  input  logic [NM*DW-1:0]  iMstWData,
  output logic [NM-1:0]     oMstAck,
  output logic [NM-1:0]     oMstErr,
  output logic [DW-1:0]     oMstRData,
  output logic              oSlvReq,
  output logic [CMD_W-1:0]  oSlvCmd,
  output logic [AW-1:0]     oSlvAddr,
  output logic [SW-1:0]     oSlvSel,
  output logic [DW-1:0]     oSlvWData,
  input  logic              iSlvAck,
  input  logic [DW-1:0]     iSlvRData,
  output logic [NM-1:0]     oGrant
);

  localparam int LW = $clog2(NM);
  localparam int CW = $clog2(TMO);

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NM-1:0] win;
  logic [LW-1:0] gidx;
  logic          req_g;
  logic          tmo;
  logic          done;

  rr_picker #(.NM(NM), .LW(LW)) u_pick (
    .req_i  (iMstReq),
    .last_i (last_q),
    .win_o  (win)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NM; i++)
      if (grant_q[i]) gidx = LW'(i);
  end

  assign req_g  = iMstReq[gidx];
  assign tmo    = (cnt_q == CW'(TMO - 1));
  assign oGrant = grant_q;

  // AND-OR mux; grant_q is all-zero outside BUSY so the slave sees zeros when idle.
  always_comb begin
    oSlvCmd   = '0;
    oSlvAddr  = '0;
    oSlvSel   = '0;
    oSlvWData = '0;
    for (int i = 0; i < NM; i++) begin
      if (state_q == BUSY && grant_q[i]) begin
        oSlvCmd   = oSlvCmd   | iMstCmd[i*CMD_W +: CMD_W];
        oSlvAddr  = oSlvAddr  | iMstAddr[i*AW +: AW];
        oSlvSel   = oSlvSel   | iMstSel[i*SW +: SW];
        oSlvWData = oSlvWData | iMstWData[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    oMstAck   = '0;
    oMstErr   = '0;
    oMstRData = '0;
    oSlvReq   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|iMstReq) begin
          state_d = BUSY;
          grant_d = win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        oSlvReq = req_g;
        // Slave ack beats both abort and timeout in the same cycle.
        if (iSlvAck) begin
          oMstAck   = grant_q;
          oMstRData = iSlvRData;
          done      = 1'b1;
        end else if (!req_g) begin
          done = 1'b1;
        end else if (tmo) begin
          oMstAck = grant_q;
          oMstErr = grant_q;
          oSlvReq = 1'b0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Cycle-by-cycle vector table for bus_arbiter (NM=4, TMO=4) plus short field-mux sequences.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NM = 4, CMD_W = 1, AW = 12, DW = 32, SW = 4, TMO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     mst_req;
  logic [NM*CMD_W-1:0] mst_cmd;
  logic [NM*AW-1:0]  mst_addr;
  logic [NM*SW-1:0]  mst_sel;
  logic [NM*DW-1:0]  mst_wdata;
  logic [NM-1:0]     mst_ack, mst_err, grant;
  logic [DW-1:0]     mst_rdata;
  logic              slv_req, slv_ack;
  logic [CMD_W-1:0]  slv_cmd;
  logic [AW-1:0]     slv_addr;
  logic [SW-1:0]     slv_sel;
  logic [DW-1:0]     slv_wdata, slv_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.NM(NM), .CMD_W(CMD_W), .AW(AW), .DW(DW), .SW(SW), .TMO(TMO)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .iMstReq(mst_req), .iMstCmd(mst_cmd), .iMstAddr(mst_addr), .iMstSel(mst_sel),
    .iMstWData(mst_wdata), .oMstAck(mst_ack), .oMstErr(mst_err), .oMstRData(mst_rdata),
    .oSlvReq(slv_req), .oSlvCmd(slv_cmd), .oSlvAddr(slv_addr), .oSlvSel(slv_sel),
    .oSlvWData(slv_wdata), .iSlvAck(slv_ack), .iSlvRData(slv_rdata), .oGrant(grant)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        sack;
    logic [31:0] srd;
    logic [3:0]  grant, ack, err;
    logic        sreq;
    logic [11:0] saddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vidx  = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic sa, input logic [31:0] sd,
                     input logic [3:0] g, input logic [3:0] a, input logic [3:0] e,
                     input logic sr, input logic [11:0] ad, input logic [31:0] rd);
    vec_t v;
    v.rst_n = r;  v.req = rq; v.sack = sa; v.srd = sd;
    v.grant = g;  v.ack = a;  v.err = e;   v.sreq = sr; v.saddr = ad; v.rdata = rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @step %0d: got %h, want %h", name, vidx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mst_req = '0; slv_ack = 1'b0; slv_rdata = '0;
    mst_cmd   = {CMD_WR, CMD_RD, CMD_WR, CMD_WR};
    mst_addr  = {12'h3C0, 12'h100, 12'h010, 12'h004};
    mst_sel   = {4'h1, 4'hC, 4'hF, 4'h3};
    mst_wdata = {32'h33333333, 32'h22222222, 32'hA5A5A5A5, 32'h11111111};

    //  rst req     ack srd            grant   ack     err     sreq addr    rdata
    // reset, then master 1 write acked in its 3rd busy cycle
    add(0, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(0, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0010, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0010, 0, 0,             4'b0010,4'b0000,4'b0000,1, 12'h010, 0);
    add(1, 4'b0010, 0, 0,             4'b0010,4'b0000,4'b0000,1, 12'h010, 0);
    add(1, 4'b0010, 1, 0,             4'b0010,4'b0010,4'b0000,1, 12'h010, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // master 2 read, rdata only in the ack cycle
    add(1, 4'b0100, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0100, 1, 32'hDEADBEEF,  4'b0100,4'b0100,4'b0000,1, 12'h100, 32'hDEADBEEF);
    add(1, 4'b0000, 0, 32'hDEADBEEF,  4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // stray ack in idle, then arbitration still works (last=2 -> master 0)
    add(1, 4'b0000, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0001, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0001, 1, 0,             4'b0001,4'b0001,4'b0000,1, 12'h004, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // reset, then all four request with immediate acks: 0,1,2,3,0
    add(0, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b0001,4'b0001,4'b0000,1, 12'h004, 0);
    add(1, 4'b1111, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b0010,4'b0010,4'b0000,1, 12'h010, 0);
    add(1, 4'b1111, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b0100,4'b0100,4'b0000,1, 12'h100, 0);
    add(1, 4'b1111, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b1000,4'b1000,4'b0000,1, 12'h3C0, 0);
    add(1, 4'b1111, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1111, 1, 0,             4'b0001,4'b0001,4'b0000,1, 12'h004, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // timeout on master 0 in 4th busy cycle; master 1 granted next
    add(1, 4'b0001, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0001, 0, 0,             4'b0001,4'b0000,4'b0000,1, 12'h004, 0);
    add(1, 4'b0011, 0, 0,             4'b0001,4'b0000,4'b0000,1, 12'h004, 0);
    add(1, 4'b0011, 0, 0,             4'b0001,4'b0000,4'b0000,1, 12'h004, 0);
    add(1, 4'b0011, 0, 0,             4'b0001,4'b0001,4'b0001,0, 12'h004, 0);
    add(1, 4'b0010, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0010, 1, 0,             4'b0010,4'b0010,4'b0000,1, 12'h010, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // ack coinciding with timeout: ack wins, no error
    add(1, 4'b0100, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0100, 0, 0,             4'b0100,4'b0000,4'b0000,1, 12'h100, 0);
    add(1, 4'b0100, 0, 0,             4'b0100,4'b0000,4'b0000,1, 12'h100, 0);
    add(1, 4'b0100, 0, 0,             4'b0100,4'b0000,4'b0000,1, 12'h100, 0);
    add(1, 4'b0100, 1, 32'h000000AA,  4'b0100,4'b0100,4'b0000,1, 12'h100, 32'h000000AA);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // master 3 aborts mid-transaction
    add(1, 4'b1000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b1000, 0, 0,             4'b1000,4'b0000,4'b0000,1, 12'h3C0, 0);
    add(1, 4'b0000, 0, 0,             4'b1000,4'b0000,4'b0000,0, 12'h3C0, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    // reset mid-busy on master 1; master 0 wins afterwards
    add(1, 4'b0010, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0010, 0, 0,             4'b0010,4'b0000,4'b0000,1, 12'h010, 0);
    add(0, 4'b0011, 0, 0,             4'b0010,4'b0000,4'b0000,1, 12'h010, 0);
    add(1, 4'b0011, 1, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);
    add(1, 4'b0011, 1, 0,             4'b0001,4'b0001,4'b0000,1, 12'h004, 0);
    add(1, 4'b0000, 0, 0,             4'b0000,4'b0000,4'b0000,0, 12'h000, 0);

    #1;
    foreach (tbl[i]) begin
      vidx      = i;
      rst_n     = tbl[i].rst_n;
      mst_req   = tbl[i].req;
      slv_ack   = tbl[i].sack;
      slv_rdata = tbl[i].srd;
      @(negedge clk);
      chk("grant", 32'(grant),     32'(tbl[i].grant));
      chk("ack",   32'(mst_ack),   32'(tbl[i].ack));
      chk("err",   32'(mst_err),   32'(tbl[i].err));
      chk("sreq",  32'(slv_req),   32'(tbl[i].sreq));
      chk("saddr", 32'(slv_addr),  32'(tbl[i].saddr));
      chk("rdata", mst_rdata,      tbl[i].rdata);
      tick();
    end

    // Field muxing: master 1 write then master 2 read (last_grant = 0 here)
    vidx = 1000;
    rst_n = 1'b1; mst_req = 4'b0010; slv_ack = 1'b0; slv_rdata = '0;
    tick();
    @(negedge clk);
    chk("wr_cmd",   32'(slv_cmd),   32'(CMD_WR));
    chk("wr_sel",   32'(slv_sel),   32'hF);
    chk("wr_wdata", slv_wdata,      32'hA5A5A5A5);
    chk("wr_grant", 32'(grant),     32'b0010);
    slv_ack = 1'b1;
    #1;
    chk("wr_ack",   32'(mst_ack),   32'b0010);
    tick();
    vidx = 1001;
    mst_req = 4'b0100; slv_ack = 1'b0;
    tick();
    @(negedge clk);
    chk("rd_cmd",   32'(slv_cmd),   32'(CMD_RD));
    chk("rd_sel",   32'(slv_sel),   32'hC);
    chk("rd_wdata", slv_wdata,      32'h22222222);
    slv_ack = 1'b1; slv_rdata = 32'hCAFEF00D;
    #1;
    chk("rd_ack",   32'(mst_ack),   32'b0100);
    chk("rd_data",  mst_rdata,      32'hCAFEF00D);
    tick();
    mst_req = '0; slv_ack = 1'b0;
    @(negedge clk);
    chk("end_grant", 32'(grant),    32'h0);
    chk("end_sel",   32'(slv_sel),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
